packet_pingpong_buf: RTL and testbench

//  Ping-pong packet store between dist_measure (producer) and w5500_control (consumer).
//  Two 1 KiB byte banks are written with the o_packet_* stream. Each completed bank is published

---
 rtl/pkt_buf_pkg.sv | 24 ++
 rtl/packet_pingpong_buf_if.sv | 56 +++++
 rtl/pkt_dpram_2kx8.sv | 27 ++
 rtl/packet_pingpong_buf.sv | 180 ++++++++++++++++++
 tb/tb_packet_pingpong_buf.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pkt_buf_pkg.sv
// Shared types and default widths for the ping-pong packet buffer.
// Bank states: FREE empty | FILLING producer writing | READY awaiting take | SENDING owned by reader.
package pkt_buf_pkg;
  localparam int PKT_AW     = 10;
  localparam int DROP_W_DEF = 16;
  localparam int POINTS_W   = 16;
  localparam int SCAN_W     = 16;
  localparam int TEL_W      = 8;
  localparam int ANGLE_W    = 16;
  localparam int CSUM_W     = 16;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2,
    BANK_SENDING = 2'd3
  } bank_state_e;

  typedef struct packed {
    logic [SCAN_W-1:0]  scan_counter;
    logic [TEL_W-1:0]   telegram_no;
    logic [ANGLE_W-1:0] first_angle;
  } pkt_hdr_t;
endpackage

// File: rtl/packet_pingpong_buf_if.sv
// Producer/consumer bundle of the ping-pong packet buffer; slave = buffer, master = its peers.
// PKT_CHECKSUM_EN adds o_pkt_checksum to the bundle.
interface packet_pingpong_buf_if #(
  parameter int AW     = pkt_buf_pkg::PKT_AW,
  parameter int DROP_W = pkt_buf_pkg::DROP_W_DEF
);
  import pkt_buf_pkg::*;

  logic                 i_packet_wren;
  logic                 i_packet_pingpang;
  logic [AW-1:0]        i_packet_wraddr;
  logic [7:0]           i_packet_wrdata;
  logic                 i_packet_make;
  logic [POINTS_W-1:0]  i_packet_points;
  logic [SCAN_W-1:0]    i_scan_counter;
  logic [TEL_W-1:0]     i_telegram_no;
  logic [ANGLE_W-1:0]   i_first_angle;
  logic                 o_pkt_valid;
  logic                 o_pkt_bank;
  logic [AW:0]          o_pkt_len;
  logic [SCAN_W-1:0]    o_pkt_scan_counter;
  logic [TEL_W-1:0]     o_pkt_telegram_no;
  logic [ANGLE_W-1:0]   o_pkt_first_angle;
  logic                 i_pkt_take;
  logic [AW-1:0]        i_rd_addr;
  logic [7:0]           o_rd_data;
  logic                 i_pkt_done;
  logic                 o_len_clamp;
  logic [DROP_W-1:0]    o_drop_cnt;
  logic [DROP_W-1:0]    o_wr_reject_cnt;
`ifdef PKT_CHECKSUM_EN
  logic [CSUM_W-1:0]    o_pkt_checksum;
`endif

  modport slave (
    input  i_packet_wren, i_packet_pingpang, i_packet_wraddr, i_packet_wrdata,
    input  i_packet_make, i_packet_points, i_scan_counter, i_telegram_no, i_first_angle,
    input  i_pkt_take, i_rd_addr, i_pkt_done,
`ifdef PKT_CHECKSUM_EN
    output o_pkt_checksum,
`endif
    output o_pkt_valid, o_pkt_bank, o_pkt_len, o_pkt_scan_counter, o_pkt_telegram_no,
    output o_pkt_first_angle, o_rd_data, o_len_clamp, o_drop_cnt, o_wr_reject_cnt
  );

  modport master (
    output i_packet_wren, i_packet_pingpang, i_packet_wraddr, i_packet_wrdata,
    output i_packet_make, i_packet_points, i_scan_counter, i_telegram_no, i_first_angle,
    output i_pkt_take, i_rd_addr, i_pkt_done,
`ifdef PKT_CHECKSUM_EN
    input  o_pkt_checksum,
`endif
    input  o_pkt_valid, o_pkt_bank, o_pkt_len, o_pkt_scan_counter, o_pkt_telegram_no,
    input  o_pkt_first_angle, o_rd_data, o_len_clamp, o_drop_cnt, o_wr_reject_cnt
  );
endinterface

// File: rtl/pkt_dpram_2kx8.sv
// Two-bank byte store: one write port, one read port with a registered output.
// Address MSB selects the bank; contents are deliberately not cleared by reset.
module pkt_dpram_2kx8 #(
  parameter int AW = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [AW:0] i_waddr,
  input  logic [7:0]  i_wdata,
  input  logic [AW:0] i_raddr,
  output logic [7:0]  o_rdata
);
  logic [7:0] r_mem [2**(AW+1)];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rdata <= '0;
    else       r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/packet_pingpong_buf.sv
// Ping-pong packet store: two byte banks handed from the measurement producer to the W5500 reader.
// Optional PKT_CHECKSUM_EN keeps a 16-bit additive byte sum per bank.
module packet_pingpong_buf
  import pkt_buf_pkg::*;
#(
  parameter int AW     = PKT_AW,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                  i_clk_50m,
  input  logic                  i_rst,
  packet_pingpong_buf_if.slave  bus
);
  localparam int          BANK_BYTES = 2**AW;
  localparam logic [16:0] BANK_LEN   = 17'(BANK_BYTES);

  bank_state_e       r_state [2];
  bank_state_e       w_state_nxt [2];
  pkt_hdr_t          r_hdr [2];
  pkt_hdr_t          w_hdr_nxt [2];
  logic [AW:0]       r_len [2];
  logic [AW:0]       w_len_nxt [2];
  logic              r_older, w_older_nxt;
  logic              r_clamp, w_clamp_nxt;
  logic [DROP_W-1:0] r_drop_cnt, w_drop_nxt;
  logic [DROP_W-1:0] r_rej_cnt, w_rej_nxt;

  logic              r_valid, r_bank;
  pkt_hdr_t          r_pres_hdr;
  logic [AW:0]       r_pres_len;

  logic              w_bank, w_wr_ok, w_mk_ok;
  logic              w_send_any, w_send_bank;
  logic [16:0]       w_len_raw;
  logic              w_len_big;
  logic [AW:0]       w_len_clamped;
  logic              w_rdy0, w_rdy1, w_send_any_nxt;
  logic              w_valid_nxt, w_bank_nxt;
  logic [7:0]        w_rd_data;

  // Writes and makes share one bank select.
  assign w_bank      = bus.i_packet_pingpang;
  assign w_wr_ok     = bus.i_packet_wren &&
                       (r_state[w_bank] == BANK_FREE || r_state[w_bank] == BANK_FILLING);
  assign w_mk_ok     = bus.i_packet_make &&
                       (r_state[w_bank] == BANK_FREE || r_state[w_bank] == BANK_FILLING);
  assign w_send_any  = (r_state[0] == BANK_SENDING) || (r_state[1] == BANK_SENDING);
  assign w_send_bank = (r_state[1] == BANK_SENDING);

  assign w_len_raw     = {bus.i_packet_points, 1'b0};
  assign w_len_big     = w_len_raw > BANK_LEN;
  assign w_len_clamped = w_len_big ? BANK_LEN[AW:0] : w_len_raw[AW:0];

`ifdef PKT_CHECKSUM_EN
  logic [CSUM_W-1:0] r_sum [2];
  logic [CSUM_W-1:0] w_sum_nxt [2];
  logic [CSUM_W-1:0] r_pres_sum;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_nxt   = r_hdr;
    w_len_nxt   = r_len;
    w_older_nxt = r_older;
    w_clamp_nxt = r_clamp;
    w_drop_nxt  = r_drop_cnt;
    w_rej_nxt   = r_rej_cnt;
`ifdef PKT_CHECKSUM_EN
    w_sum_nxt   = r_sum;
`endif

    if (w_wr_ok) begin
      if (r_state[w_bank] == BANK_FREE) w_state_nxt[w_bank] = BANK_FILLING;
`ifdef PKT_CHECKSUM_EN
      w_sum_nxt[w_bank] = ((r_state[w_bank] == BANK_FREE) ? '0 : r_sum[w_bank]) +
                          {8'h00, bus.i_packet_wrdata};
`endif
    end else if (bus.i_packet_wren && r_rej_cnt != '1) begin
      w_rej_nxt = r_rej_cnt + DROP_W'(1);
    end

    if (bus.i_pkt_done && w_send_any) w_state_nxt[w_send_bank] = BANK_FREE;
    if (bus.i_pkt_take && r_valid)    w_state_nxt[r_bank]      = BANK_SENDING;

    if (w_mk_ok) begin
      w_state_nxt[w_bank] = BANK_READY;
      w_hdr_nxt[w_bank]   = '{scan_counter: bus.i_scan_counter,
                              telegram_no:  bus.i_telegram_no,
                              first_angle:  bus.i_first_angle};
      // A make on a FREE bank with no write landing this cycle is an empty packet.
      if (r_state[w_bank] == BANK_FREE && !w_wr_ok) begin
        w_len_nxt[w_bank] = '0;
`ifdef PKT_CHECKSUM_EN
        w_sum_nxt[w_bank] = '0;
`endif
      end else begin
        w_len_nxt[w_bank] = w_len_clamped;
        w_clamp_nxt       = r_clamp | w_len_big;
      end
      w_older_nxt = (w_state_nxt[~w_bank] == BANK_READY) ? ~w_bank : w_bank;
    end else if (bus.i_packet_make && r_drop_cnt != '1) begin
      w_drop_nxt = r_drop_cnt + DROP_W'(1);
    end
  end

  always_comb begin
    w_rdy0         = (w_state_nxt[0] == BANK_READY);
    w_rdy1         = (w_state_nxt[1] == BANK_READY);
    w_send_any_nxt = (w_state_nxt[0] == BANK_SENDING) || (w_state_nxt[1] == BANK_SENDING);
    w_valid_nxt    = !w_send_any_nxt && (w_rdy0 || w_rdy1);
    w_bank_nxt     = (w_rdy0 && w_rdy1) ? w_older_nxt : w_rdy1;
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= BANK_FREE;
        r_hdr[i]   <= '0;
        r_len[i]   <= '0;
      end
      r_older    <= 1'b0;
      r_clamp    <= 1'b0;
      r_drop_cnt <= '0;
      r_rej_cnt  <= '0;
      r_valid    <= 1'b0;
      r_bank     <= 1'b0;
      r_pres_hdr <= '0;
      r_pres_len <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hdr      <= w_hdr_nxt;
      r_len      <= w_len_nxt;
      r_older    <= w_older_nxt;
      r_clamp    <= w_clamp_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_rej_cnt  <= w_rej_nxt;
      r_valid    <= w_valid_nxt;
      if (w_valid_nxt) begin
        r_bank     <= w_bank_nxt;
        r_pres_hdr <= w_hdr_nxt[w_bank_nxt];
        r_pres_len <= w_len_nxt[w_bank_nxt];
      end
    end
  end

`ifdef PKT_CHECKSUM_EN
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      r_sum[0]   <= '0;
      r_sum[1]   <= '0;
      r_pres_sum <= '0;
    end else begin
      r_sum <= w_sum_nxt;
      if (w_valid_nxt) r_pres_sum <= w_sum_nxt[w_bank_nxt];
    end
  end

  assign bus.o_pkt_checksum = r_pres_sum;
`endif

  pkt_dpram_2kx8 #(.AW(AW)) u_ram (
    .i_clk   (i_clk_50m),
    .i_rst   (i_rst),
    .i_we    (w_wr_ok),
    .i_waddr ({w_bank, bus.i_packet_wraddr}),
    .i_wdata (bus.i_packet_wrdata),
    .i_raddr ({w_send_bank, bus.i_rd_addr}),
    .o_rdata (w_rd_data)
  );

  assign bus.o_pkt_valid        = r_valid;
  assign bus.o_pkt_bank         = r_bank;
  assign bus.o_pkt_len          = r_pres_len;
  assign bus.o_pkt_scan_counter = r_pres_hdr.scan_counter;
  assign bus.o_pkt_telegram_no  = r_pres_hdr.telegram_no;
  assign bus.o_pkt_first_angle  = r_pres_hdr.first_angle;
  assign bus.o_rd_data          = w_rd_data;
  assign bus.o_len_clamp        = r_clamp;
  assign bus.o_drop_cnt         = r_drop_cnt;
  assign bus.o_wr_reject_cnt    = r_rej_cnt;
endmodule

// File: tb/tb_packet_pingpong_buf.sv
// Directed bench for packet_pingpong_buf; inputs change and outputs are sampled on the falling edge.
module tb_packet_pingpong_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  packet_pingpong_buf_if #(.AW(10), .DROP_W(16)) bus ();

  packet_pingpong_buf #(.AW(10), .DROP_W(16)) dut (
    .i_clk_50m (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic b, input logic [9:0] a, input logic [7:0] d);
    bus.i_packet_wren = 1'b1; bus.i_packet_pingpang = b;
    bus.i_packet_wraddr = a;  bus.i_packet_wrdata = d;
    step();
    bus.i_packet_wren = 1'b0;
  endtask

  task automatic mk(input logic b, input logic [15:0] pts, input logic [15:0] sc,
                    input logic [7:0] tel, input logic [15:0] ang);
    bus.i_packet_make = 1'b1; bus.i_packet_pingpang = b; bus.i_packet_points = pts;
    bus.i_scan_counter = sc;  bus.i_telegram_no = tel;   bus.i_first_angle = ang;
    step();
    bus.i_packet_make = 1'b0;
  endtask

  task automatic take_pkt();
    bus.i_pkt_take = 1'b1; step(); bus.i_pkt_take = 1'b0;
  endtask

  task automatic done_pkt();
    bus.i_pkt_done = 1'b1; step(); bus.i_pkt_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (bus.o_pkt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0h want 0", bus.o_pkt_valid); end
    n_cmp++; if (bus.o_pkt_len !== 11'd0) begin n_bad++; $display("FAIL rst_len got %0d want 0", bus.o_pkt_len); end
    n_cmp++; if (bus.o_pkt_scan_counter !== 16'h0) begin n_bad++; $display("FAIL rst_scan got %0h want 0", bus.o_pkt_scan_counter); end
    n_cmp++; if (bus.o_drop_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_drop got %0d want 0", bus.o_drop_cnt); end
    n_cmp++; if (bus.o_wr_reject_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_reject got %0d want 0", bus.o_wr_reject_cnt); end
    n_cmp++; if (bus.o_len_clamp !== 1'b0) begin n_bad++; $display("FAIL rst_clamp got %0h want 0", bus.o_len_clamp); end
    n_cmp++; if (bus.o_rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd_data got %0h want 0", bus.o_rd_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 120; i++) wr(1'b0, 10'(i), 8'(i));
    mk(1'b0, 16'd60, 16'h1234, 8'h56, 16'h789A);
    n_cmp++; if (bus.o_pkt_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0h want 1", bus.o_pkt_valid); end
    n_cmp++; if (bus.o_pkt_bank !== 1'b0) begin n_bad++; $display("FAIL basic_bank got %0h want 0", bus.o_pkt_bank); end
    n_cmp++; if (bus.o_pkt_len !== 11'd120) begin n_bad++; $display("FAIL basic_len got %0d want 120", bus.o_pkt_len); end
    n_cmp++; if (bus.o_pkt_scan_counter !== 16'h1234) begin n_bad++; $display("FAIL basic_scan got %0h want 1234", bus.o_pkt_scan_counter); end
    n_cmp++; if (bus.o_pkt_telegram_no !== 8'h56) begin n_bad++; $display("FAIL basic_tel got %0h want 56", bus.o_pkt_telegram_no); end
    n_cmp++; if (bus.o_pkt_first_angle !== 16'h789A) begin n_bad++; $display("FAIL basic_angle got %0h want 789a", bus.o_pkt_first_angle); end
    take_pkt();
    n_cmp++; if (bus.o_pkt_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_sending got %0h want 0", bus.o_pkt_valid); end
    bus.i_rd_addr = 10'd5; step();
    n_cmp++; if (bus.o_rd_data !== 8'h05) begin n_bad++; $display("FAIL basic_rd5 got %0h want 05", bus.o_rd_data); end
    bus.i_rd_addr = 10'd119; step();
    n_cmp++; if (bus.o_rd_data !== 8'h77) begin n_bad++; $display("FAIL basic_rd119 got %0h want 77", bus.o_rd_data); end
    done_pkt();
    n_cmp++; if (bus.o_pkt_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_done got %0h want 0", bus.o_pkt_valid); end
  endtask

  task automatic test_order();
    wr(1'b0, 10'd0, 8'hAA);
    wr(1'b1, 10'd0, 8'hBB);
    mk(1'b0, 16'd10, 16'h0001, 8'h01, 16'h0010);
    n_cmp++; if (bus.o_pkt_len !== 11'd20) begin n_bad++; $display("FAIL order_len0 got %0d want 20", bus.o_pkt_len); end
    mk(1'b1, 16'd20, 16'h0002, 8'h02, 16'h0020);
    n_cmp++; if (bus.o_pkt_bank !== 1'b0) begin n_bad++; $display("FAIL order_older_bank got %0h want 0", bus.o_pkt_bank); end
    n_cmp++; if (bus.o_pkt_scan_counter !== 16'h0001) begin n_bad++; $display("FAIL order_older_scan got %0h want 1", bus.o_pkt_scan_counter); end
    take_pkt();
    n_cmp++; if (bus.o_pkt_valid !== 1'b0) begin n_bad++; $display("FAIL order_valid_sending got %0h want 0", bus.o_pkt_valid); end
    done_pkt();
    n_cmp++; if (bus.o_pkt_valid !== 1'b1) begin n_bad++; $display("FAIL order_valid_next got %0h want 1", bus.o_pkt_valid); end
    n_cmp++; if (bus.o_pkt_bank !== 1'b1) begin n_bad++; $display("FAIL order_bank_next got %0h want 1", bus.o_pkt_bank); end
    n_cmp++; if (bus.o_pkt_len !== 11'd40) begin n_bad++; $display("FAIL order_len1 got %0d want 40", bus.o_pkt_len); end
    n_cmp++; if (bus.o_pkt_scan_counter !== 16'h0002) begin n_bad++; $display("FAIL order_scan1 got %0h want 2", bus.o_pkt_scan_counter); end
    take_pkt();
    bus.i_rd_addr = 10'd0; step();
    n_cmp++; if (bus.o_rd_data !== 8'hBB) begin n_bad++; $display("FAIL order_rd_bank1 got %0h want bb", bus.o_rd_data); end
    done_pkt();
  endtask

  task automatic test_drop();
    wr(1'b0, 10'd1, 8'h11);
    mk(1'b0, 16'd4, 16'h0101, 8'h03, 16'h0030);
    mk(1'b0, 16'd99, 16'hFFFF, 8'hFF, 16'hFFFF);
    n_cmp++; if (bus.o_drop_cnt !== 16'd1) begin n_bad++; $display("FAIL drop_ready_cnt got %0d want 1", bus.o_drop_cnt); end
    n_cmp++; if (bus.o_pkt_len !== 11'd8) begin n_bad++; $display("FAIL drop_len_kept got %0d want 8", bus.o_pkt_len); end
    n_cmp++; if (bus.o_pkt_scan_counter !== 16'h0101) begin n_bad++; $display("FAIL drop_scan_kept got %0h want 101", bus.o_pkt_scan_counter); end
    take_pkt();
    mk(1'b0, 16'd33, 16'h0BAD, 8'h00, 16'h0000);
    n_cmp++; if (bus.o_drop_cnt !== 16'd2) begin n_bad++; $display("FAIL drop_sending_cnt got %0d want 2", bus.o_drop_cnt); end
    for (int i = 0; i < 3; i++) wr(1'b0, 10'd2, 8'hEE);
    n_cmp++; if (bus.o_wr_reject_cnt !== 16'd3) begin n_bad++; $display("FAIL reject_cnt got %0d want 3", bus.o_wr_reject_cnt); end
    bus.i_rd_addr = 10'd2; step();
    n_cmp++; if (bus.o_rd_data !== 8'h02) begin n_bad++; $display("FAIL reject_ram_kept got %0h want 02", bus.o_rd_data); end
    done_pkt();
    n_cmp++; if (bus.o_pkt_valid !== 1'b0) begin n_bad++; $display("FAIL drop_valid_done got %0h want 0", bus.o_pkt_valid); end
  endtask

  task automatic test_empty();
    mk(1'b1, 16'd50, 16'h0E0E, 8'h0E, 16'h0E0E);
    n_cmp++; if (bus.o_pkt_valid !== 1'b1 || bus.o_pkt_bank !== 1'b1) begin n_bad++; $display("FAIL empty_present got valid %0h bank %0h want 1 1", bus.o_pkt_valid, bus.o_pkt_bank); end
    n_cmp++; if (bus.o_pkt_len !== 11'd0) begin n_bad++; $display("FAIL empty_len got %0d want 0", bus.o_pkt_len); end
    take_pkt();
    done_pkt();
  endtask

  task automatic test_clamp();
    wr(1'b0, 10'd0, 8'h01);
    mk(1'b0, 16'd512, 16'h0200, 8'h04, 16'h0040);
    n_cmp++; if (bus.o_pkt_len !== 11'd1024) begin n_bad++; $display("FAIL clamp_exact_len got %0d want 1024", bus.o_pkt_len); end
    n_cmp++; if (bus.o_len_clamp !== 1'b0) begin n_bad++; $display("FAIL clamp_exact_flag got %0h want 0", bus.o_len_clamp); end
    take_pkt(); done_pkt();
    wr(1'b1, 10'd0, 8'h01);
    mk(1'b1, 16'd600, 16'h0258, 8'h05, 16'h0050);
    n_cmp++; if (bus.o_pkt_len !== 11'd1024) begin n_bad++; $display("FAIL clamp_len got %0d want 1024", bus.o_pkt_len); end
    n_cmp++; if (bus.o_len_clamp !== 1'b1) begin n_bad++; $display("FAIL clamp_flag got %0h want 1", bus.o_len_clamp); end
    take_pkt(); done_pkt();
    n_cmp++; if (bus.o_len_clamp !== 1'b1) begin n_bad++; $display("FAIL clamp_sticky got %0h want 1", bus.o_len_clamp); end
  endtask

  task automatic test_same_cycle();
    bus.i_packet_wren = 1'b1; bus.i_packet_wraddr = 10'd3; bus.i_packet_wrdata = 8'hAB;
    mk(1'b0, 16'd2, 16'h0A0A, 8'h0A, 16'h0A0A);
    bus.i_packet_wren = 1'b0;
    n_cmp++; if (bus.o_pkt_valid !== 1'b1 || bus.o_pkt_bank !== 1'b0) begin n_bad++; $display("FAIL wrmk_present got valid %0h bank %0h want 1 0", bus.o_pkt_valid, bus.o_pkt_bank); end
    n_cmp++; if (bus.o_pkt_len !== 11'd4) begin n_bad++; $display("FAIL wrmk_len got %0d want 4", bus.o_pkt_len); end
    wr(1'b1, 10'd0, 8'hCD);
    bus.i_pkt_take = 1'b1;
    mk(1'b1, 16'd3, 16'h0B0B, 8'h0B, 16'h0B0B);
    bus.i_pkt_take = 1'b0;
    n_cmp++; if (bus.o_pkt_valid !== 1'b0) begin n_bad++; $display("FAIL takemk_valid got %0h want 0", bus.o_pkt_valid); end
    bus.i_rd_addr = 10'd3; step();
    n_cmp++; if (bus.o_rd_data !== 8'hAB) begin n_bad++; $display("FAIL wrmk_rd got %0h want ab", bus.o_rd_data); end
    done_pkt();
    n_cmp++; if (bus.o_pkt_valid !== 1'b1 || bus.o_pkt_bank !== 1'b1) begin n_bad++; $display("FAIL takemk_next got valid %0h bank %0h want 1 1", bus.o_pkt_valid, bus.o_pkt_bank); end
    n_cmp++; if (bus.o_pkt_len !== 11'd6) begin n_bad++; $display("FAIL takemk_len got %0d want 6", bus.o_pkt_len); end
    take_pkt();
    wr(1'b0, 10'd0, 8'h77);
    bus.i_pkt_done = 1'b1;
    mk(1'b0, 16'd7, 16'h0C0C, 8'h0C, 16'h0C0C);
    bus.i_pkt_done = 1'b0;
    n_cmp++; if (bus.o_pkt_valid !== 1'b1 || bus.o_pkt_bank !== 1'b0) begin n_bad++; $display("FAIL donemk_present got valid %0h bank %0h want 1 0", bus.o_pkt_valid, bus.o_pkt_bank); end
    n_cmp++; if (bus.o_pkt_len !== 11'd14) begin n_bad++; $display("FAIL donemk_len got %0d want 14", bus.o_pkt_len); end
    take_pkt();
    rst = 1'b1; step();
    n_cmp++; if (bus.o_pkt_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %0h want 0", bus.o_pkt_valid); end
    n_cmp++; if (bus.o_drop_cnt !== 16'd0 || bus.o_wr_reject_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_cnts got drop %0d rej %0d want 0 0", bus.o_drop_cnt, bus.o_wr_reject_cnt); end
    n_cmp++; if (bus.o_len_clamp !== 1'b0) begin n_bad++; $display("FAIL midrst_clamp got %0h want 0", bus.o_len_clamp); end
    n_cmp++; if (bus.o_pkt_len !== 11'd0 || bus.o_rd_data !== 8'h00) begin n_bad++; $display("FAIL midrst_len_rd got len %0d rd %0h want 0 0", bus.o_pkt_len, bus.o_rd_data); end
    rst = 1'b0; step();
    wr(1'b0, 10'd0, 8'h01);
    n_cmp++; if (bus.o_wr_reject_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_bank_free got rej %0d want 0", bus.o_wr_reject_cnt); end
  endtask

`ifdef PKT_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 1; i <= 16; i++) wr(1'b1, 10'(i - 1), 8'(i));
    mk(1'b1, 16'd8, 16'h0D0D, 8'h0D, 16'h0D0D);
    n_cmp++; if (bus.o_pkt_bank !== 1'b1 || bus.o_pkt_len !== 11'd16) begin n_bad++; $display("FAIL csum_present got bank %0h len %0d want 1 16", bus.o_pkt_bank, bus.o_pkt_len); end
    n_cmp++; if (bus.o_pkt_checksum !== 16'h0088) begin n_bad++; $display("FAIL csum_value got %0h want 0088", bus.o_pkt_checksum); end
    take_pkt(); done_pkt();
  endtask
`endif

  initial begin
    bus.i_packet_wren = 1'b0; bus.i_packet_pingpang = 1'b0; bus.i_packet_wraddr = '0;
    bus.i_packet_wrdata = '0; bus.i_packet_make = 1'b0;   bus.i_packet_points = '0;
    bus.i_scan_counter = '0;  bus.i_telegram_no = '0;     bus.i_first_angle = '0;
    bus.i_pkt_take = 1'b0;    bus.i_rd_addr = '0;         bus.i_pkt_done = 1'b0;
    test_reset();
    test_basic();
    test_order();
    test_drop();
    test_empty();
    test_clamp();
    test_same_cycle();
`ifdef PKT_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
